// File: rtl/exu_issue_ctrl_if.sv
// Decoder/EXU signal bundle for exu_issue_ctrl: decoded instruction, unit done
// pulses in; stall, unit start, writeback sequencing and status out.
interface exu_issue_ctrl_if;
  // Decoded instruction from the decoder
  logic       iValid;
  logic [1:0] iExuOp;
  logic       iEnWrite;
  logic [4:0] iAddrWrite;
  logic       iEnRead0;
  logic [4:0] iAddrRead0;
  logic       iEnRead1;
  logic [4:0] iAddrRead1;

  // Completion pulses from the multi-cycle units
  logic       iMduDone;
  logic       iFpuDone;

  // Controller outputs
  logic       oStall;
  logic       oMduStart;
  logic       oFpuStart;
  logic       oWbEn;
  logic [4:0] oWbAddr;
  logic       oWbSel;
  logic       oBusy;
  logic       oTimeout;

  // Decoder / EXU side
  modport master (
    output iValid, iExuOp, iEnWrite, iAddrWrite,
    output iEnRead0, iAddrRead0, iEnRead1, iAddrRead1,
    output iMduDone, iFpuDone,
    input  oStall, oMduStart, oFpuStart, oWbEn, oWbAddr, oWbSel, oBusy, oTimeout
  );

  // Issue controller side
  modport slave (
    input  iValid, iExuOp, iEnWrite, iAddrWrite,
    input  iEnRead0, iAddrRead0, iEnRead1, iAddrRead1,
    input  iMduDone, iFpuDone,
    output oStall, oMduStart, oFpuStart, oWbEn, oWbAddr, oWbSel, oBusy, oTimeout
  );
endinterface

// File: rtl/exu_issue_ctrl.sv
// Issue controller for the MDU/FPU: one outstanding multi-cycle op, hazard stall, WB slot.
// Optional watchdog on the WAIT state enabled by defining EXU_TIMEOUT_EN.
module exu_issue_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input logic             iClk,
  input logic             iRst_n,
  exu_issue_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StWait  = 2'd2,
    StWb    = 2'd3
  } state_e;

  localparam logic [1:0] OpMdu = 2'b01;
  localparam logic [1:0] OpFpu = 2'b10;

  if (TIMEOUT_CYCLES < 1) begin : gCfgCheck
    $error("exu_issue_ctrl: TIMEOUT_CYCLES must be at least 1");
  end

  state_e     stateQ, stateD;
  logic [4:0] pendAddrQ, pendAddrD;
  logic       pendEnQ, pendEnD;
  logic       pendSelQ, pendSelD;

  logic isMulti;
  logic hazard;
  logic unitDone;
  logic timeoutHit;

  assign isMulti = (bus.iExuOp == OpMdu) || (bus.iExuOp == OpFpu);

  // Register 0 is tracked like any other destination.
  assign hazard = pendEnQ & ((bus.iEnRead0 & (bus.iAddrRead0 == pendAddrQ)) |
                             (bus.iEnRead1 & (bus.iAddrRead1 == pendAddrQ)) |
                             (bus.iEnWrite & (bus.iAddrWrite == pendAddrQ)));

  // Only the unit that was launched can end the wait.
  assign unitDone = pendSelQ ? bus.iFpuDone : bus.iMduDone;

`ifdef EXU_TIMEOUT_EN
  localparam int unsigned     CntW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLimit = CntW'(TIMEOUT_CYCLES);

  logic [CntW-1:0] cntQ, cntD;

  assign timeoutHit = (stateQ == StWait) && (cntQ == CntLimit);

  always_comb begin
    cntD = cntQ;
    if (stateQ == StStart) begin
      cntD = '0;
    end else if ((stateQ == StWait) && !unitDone && !timeoutHit) begin
      cntD = cntQ + CntW'(1);
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      cntQ <= '0;
    end else begin
      cntQ <= cntD;
    end
  end
`else
  assign timeoutHit = 1'b0;
`endif

  always_comb begin
    stateD     = stateQ;
    pendAddrD  = pendAddrQ;
    pendEnD    = pendEnQ;
    pendSelD   = pendSelQ;
    bus.oStall = 1'b0;
    case (stateQ)
      StIdle: begin
        if (bus.iValid && isMulti) begin
          pendAddrD = bus.iAddrWrite;
          pendEnD   = bus.iEnWrite;
          pendSelD  = (bus.iExuOp == OpFpu);
          stateD    = StStart;
        end
      end
      StStart: begin
        // A done pulse here cannot belong to this op; the unit has not seen start yet.
        bus.oStall = bus.iValid & (isMulti | hazard);
        stateD     = StWait;
      end
      StWait: begin
        bus.oStall = bus.iValid & (isMulti | hazard);
        if (unitDone) begin
          stateD = StWb;
        end else if (timeoutHit) begin
          pendEnD = 1'b0;
          stateD  = StIdle;
        end
      end
      StWb: begin
        // The writeback port belongs to the controller this cycle.
        bus.oStall = bus.iValid;
        stateD     = StIdle;
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      stateQ    <= StIdle;
      pendAddrQ <= '0;
      pendEnQ   <= 1'b0;
      pendSelQ  <= 1'b0;
    end else begin
      stateQ    <= stateD;
      pendAddrQ <= pendAddrD;
      pendEnQ   <= pendEnD;
      pendSelQ  <= pendSelD;
    end
  end

  assign bus.oMduStart = (stateQ == StStart) & ~pendSelQ;
  assign bus.oFpuStart = (stateQ == StStart) & pendSelQ;
  assign bus.oWbEn     = (stateQ == StWb) & pendEnQ;
  assign bus.oWbAddr   = (stateQ == StWb) ? pendAddrQ : 5'd0;
  assign bus.oWbSel    = (stateQ == StWb) & pendSelQ;
  assign bus.oBusy     = (stateQ != StIdle);
  assign bus.oTimeout  = timeoutHit;

endmodule

// File: tb/tb_exu_issue_ctrl.sv
// Directed bench for exu_issue_ctrl; writebacks are predicted into a scoreboard
// when the launching instruction is driven and checked when oWbEn appears.
module tb_exu_issue_ctrl;

  localparam int unsigned TbTimeout = 8;

  logic iClk   = 1'b0;
  logic iRst_n = 1'b0;

  int testsRun    = 0;
  int testsFailed = 0;

  typedef struct packed {
    logic [4:0] addr;
    logic       sel;
  } wb_t;

  wb_t sbQ[$];
  wb_t sbHead;

  exu_issue_ctrl_if bus();

  exu_issue_ctrl #(
    .TIMEOUT_CYCLES(TbTimeout)
  ) dut (
    .iClk  (iClk),
    .iRst_n(iRst_n),
    .bus   (bus)
  );

  always #5 iClk = ~iClk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Packed control view: {stall, mduStart, fpuStart, wbEn, busy, timeout}
  function automatic logic [7:0] ctl();
    return {2'b00, bus.oStall, bus.oMduStart, bus.oFpuStart, bus.oWbEn, bus.oBusy, bus.oTimeout};
  endfunction

  task automatic checkCtl(input string tag, input logic [5:0] exp);
    #1;
    check(tag, ctl(), {2'b00, exp});
  endtask

  task automatic tick();
    @(posedge iClk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic we, input logic [4:0] wa,
                       input logic r0e, input logic [4:0] r0, input logic r1e,
                       input logic [4:0] r1);
    bus.iValid     = v;
    bus.iExuOp     = op;
    bus.iEnWrite   = we;
    bus.iAddrWrite = wa;
    bus.iEnRead0   = r0e;
    bus.iAddrRead0 = r0;
    bus.iEnRead1   = r1e;
    bus.iAddrRead1 = r1;
  endtask

  task automatic noInstr();
    drive(1'b0, 2'b00, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
  endtask

  always @(negedge iClk) begin
    if (iRst_n && bus.oWbEn) begin
      check("wb_expected", 8'(sbQ.size() != 0), 8'd1);
      if (sbQ.size() != 0) begin
        sbHead = sbQ.pop_front();
        check("wb_addr", 8'(bus.oWbAddr), 8'(sbHead.addr));
        check("wb_sel", 8'(bus.oWbSel), 8'(sbHead.sel));
      end
    end
  end

  initial begin
    bus.iMduDone = 1'b0;
    bus.iFpuDone = 1'b0;

    // Reset with an MDU request sitting on the inputs
    drive(1'b1, 2'b01, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0);
    repeat (3) @(posedge iClk);
    #2;
    checkCtl("reset_ctl", 6'b000000);
    check("reset_wbaddr", 8'(bus.oWbAddr), 8'd0);
    check("reset_wbsel", 8'(bus.oWbSel), 8'd0);

    // MDU -> r5 accepted on the next edge
    iRst_n = 1'b1;
    sbQ.push_back('{addr: 5'd5, sel: 1'b0});
    tick();
    checkCtl("start_mdu_held", 6'b110010);
    drive(1'b1, 2'b00, 1'b1, 5'd6, 1'b1, 5'd3, 1'b1, 5'd4);
    checkCtl("start_alu_indep", 6'b010010);
    tick();
    checkCtl("wait1_alu_indep", 6'b000010);
    drive(1'b1, 2'b00, 1'b1, 5'd6, 1'b0, 5'd0, 1'b1, 5'd5);
    checkCtl("wait1_raw_r1", 6'b100010);
    tick();
    drive(1'b1, 2'b10, 1'b1, 5'd8, 1'b1, 5'd1, 1'b1, 5'd2);
    checkCtl("wait2_fpu_op", 6'b100010);
    drive(1'b1, 2'b00, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0);
    checkCtl("wait2_waw", 6'b100010);
    tick();
    drive(1'b1, 2'b00, 1'b1, 5'd6, 1'b1, 5'd5, 1'b0, 5'd0);
    checkCtl("wait3_raw_r0", 6'b100010);
    tick();
    noInstr();
    bus.iMduDone = 1'b1;
    checkCtl("wait4_done", 6'b000010);
    tick();
    bus.iMduDone = 1'b0;
    checkCtl("wb_mdu", 6'b000110);
    check("wb_mdu_addr", 8'(bus.oWbAddr), 8'd5);
    drive(1'b1, 2'b00, 1'b1, 5'd6, 1'b1, 5'd3, 1'b0, 5'd0);
    checkCtl("wb_stall", 6'b100110);
    tick();
    drive(1'b1, 2'b00, 1'b1, 5'd6, 1'b1, 5'd5, 1'b0, 5'd0);
    checkCtl("idle_after_wb", 6'b000000);

    // FPU -> r9; early done and MDU done must both be ignored
    drive(1'b1, 2'b10, 1'b1, 5'd9, 1'b1, 5'd1, 1'b0, 5'd0);
    sbQ.push_back('{addr: 5'd9, sel: 1'b1});
    tick();
    noInstr();
    bus.iFpuDone = 1'b1;
    checkCtl("fpu_start", 6'b001010);
    tick();
    bus.iFpuDone = 1'b0;
    checkCtl("fpu_early_done_ign", 6'b000010);
    tick();
    bus.iMduDone = 1'b1;
    checkCtl("fpu_wait_mdudone", 6'b000010);
    tick();
    bus.iMduDone = 1'b0;
    drive(1'b1, 2'b00, 1'b1, 5'd2, 1'b1, 5'd9, 1'b0, 5'd0);
    checkCtl("fpu_still_wait", 6'b100010);
    tick();
    noInstr();
    bus.iFpuDone = 1'b1;
    checkCtl("fpu_done", 6'b000010);
    tick();
    bus.iFpuDone = 1'b0;
    checkCtl("wb_fpu", 6'b000110);
    check("wb_fpu_sel", 8'(bus.oWbSel), 8'd1);
    tick();
    checkCtl("fpu_idle", 6'b000000);

    // MDU with no destination: no hazard, no writeback
    drive(1'b1, 2'b01, 1'b0, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    drive(1'b1, 2'b00, 1'b1, 5'd1, 1'b1, 5'd7, 1'b1, 5'd7);
    checkCtl("noen_no_hazard", 6'b010010);
    tick();
    noInstr();
    bus.iMduDone = 1'b1;
    tick();
    bus.iMduDone = 1'b0;
    checkCtl("noen_wb_silent", 6'b000010);
    tick();
    checkCtl("noen_idle", 6'b000000);

    // r0 destination is tracked; done at the earliest legal cycle
    drive(1'b1, 2'b01, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    sbQ.push_back('{addr: 5'd0, sel: 1'b0});
    tick();
    drive(1'b1, 2'b00, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0);
    checkCtl("r0_hazard", 6'b110010);
    tick();
    noInstr();
    bus.iMduDone = 1'b1;
    tick();
    bus.iMduDone = 1'b0;
    checkCtl("r0_wb", 6'b000110);
    tick();

    // Reset during WAIT abandons the op
    drive(1'b1, 2'b01, 1'b1, 5'd12, 1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    noInstr();
    tick();
    checkCtl("rst_pre_wait", 6'b000010);
    iRst_n = 1'b0;
    drive(1'b1, 2'b01, 1'b1, 5'd12, 1'b1, 5'd12, 1'b0, 5'd0);
    checkCtl("rst_mid_wait", 6'b000000);
    tick();
    noInstr();
    iRst_n = 1'b1;
    bus.iMduDone = 1'b1;
    checkCtl("rst_release_done", 6'b000000);
    tick();
    bus.iMduDone = 1'b0;
    checkCtl("rst_no_wb1", 6'b000000);
    tick();
    checkCtl("rst_no_wb2", 6'b000000);

`ifdef EXU_TIMEOUT_EN
    // Watchdog: no done ever arrives
    drive(1'b1, 2'b01, 1'b1, 5'd10, 1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    noInstr();
    tick();
    for (int k = 0; k < int'(TbTimeout); k++) begin
      checkCtl("to_waiting", 6'b000010);
      tick();
    end
    checkCtl("to_pulse", 6'b000011);
    tick();
    checkCtl("to_idle", 6'b000000);
    tick();
`endif

    tick();
    check("sb_empty", 8'(sbQ.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/exu_issue_ctrl.md
# exu_issue_ctrl

Issue controller for the multi-cycle execution units (MDU, FPU) sitting between the instruction decoder and the EXU. It accepts decoded instructions, launches MDU/FPU operations with a start pulse, tracks the single outstanding destination register, and stalls dependent or conflicting instructions until the unit reports done. When the unit finishes, it sequences the writeback slot. ALU instructions independent of the pending result flow through while a multi-cycle operation is in flight.

## Interface
- TIMEOUT_CYCLES, 64: watchdog limit in WAIT cycles; used only with EXU_TIMEOUT_EN.
- iClk  input  1  clock; all state updates on rising edge.
- iRst_n  input  1  asynchronous, active-low reset.
- iValid  input  1  decoded instruction present this cycle.
- iExuOp  input  2  00 ALU, 01 MDU, 10 FPU; 11 treated as ALU.
- iEnWrite / iAddrWrite  input  1 / 5  instruction writes register iAddrWrite.
- iEnRead0 / iAddrRead0  input  1 / 5  first source operand.
- iEnRead1 / iAddrRead1  input  1 / 5  second source operand.
- iMduDone  input  1  one-cycle MDU completion pulse.
- iFpuDone  input  1  one-cycle FPU completion pulse.
- oStall  output  1  instruction this cycle not accepted; decoder holds it.
- oMduStart / oFpuStart  output  1  one-cycle launch pulse to the unit.
- oWbEn  output  1  writeback of multi-cycle result this cycle.
- oWbAddr  output  5  writeback register address.
- oWbSel  output  1  0 = MDU result, 1 = FPU result.
- oBusy  output  1  state != IDLE.
- oTimeout  output  1  one-cycle watchdog pulse (0 when EXU_TIMEOUT_EN undefined).

## Operation
- States: IDLE, START, WAIT, WB. Registers: pend_addr[4:0], pend_en, pend_sel, watchdog counter (width $clog2(TIMEOUT_CYCLES+1)).
- Accept = iValid & ~oStall. IDLE with accepted iExuOp MDU/FPU: latch pend_addr=iAddrWrite, pend_en=iEnWrite, pend_sel=(iExuOp==10); go START.
- START: oMduStart or oFpuStart (per pend_sel) high exactly this cycle; go WAIT.
- WAIT: leave on done pulse of the selected unit only; other unit's done ignored. Done -> WB.
- WB: oWbEn=pend_en, oWbAddr=pend_addr, oWbSel=pend_sel; go IDLE.
- hazard = pend_en & ((iEnRead0 & iAddrRead0==pend_addr) | (iEnRead1 & iAddrRead1==pend_addr) | (iEnWrite & iAddrWrite==pend_addr)); register 0 not special-cased.
- oStall: IDLE -> 0. START/WAIT -> iValid & (iExuOp is MDU/FPU | hazard). WB -> iValid (writeback port owned by controller).
- Done pulse arriving during START is ignored (unit cannot complete before seeing start).

## Timing
- Reset (async): state IDLE, pend_* 0, counter 0; all outputs 0. Reset mid-operation abandons the operation; no writeback issued.
- Accept in cycle N -> start pulse in N+1 -> done earliest N+2 (cycle M) -> oWbEn in M+1 -> IDLE at M+2; new MDU/FPU accepted at M+2 earliest.
- Outputs oMduStart, oFpuStart, oWbEn, oWbAddr, oWbSel, oTimeout, oBusy are decoded from registered state only; oStall is combinational from state and inputs.
- Back-to-back independent ALU instructions during START/WAIT: zero stall cycles.

## Configuration
- EXU_TIMEOUT_EN defined: counter clears on entering WAIT, increments each WAIT cycle without done; on reaching TIMEOUT_CYCLES, oTimeout pulses one cycle, state -> IDLE, no writeback, pend_en cleared. Done in same cycle as limit wins (normal WB).
- Undefined: no counter, WAIT waits indefinitely, oTimeout tied 0.

## Test plan
- Reset with iValid=1, iExuOp=01: all outputs 0; release reset, MDU accepted cycle N -> oMduStart=1 at N+1 only, oBusy=1.
- MDU to r5, iMduDone 4 cycles after start -> oWbEn=1, oWbAddr=5, oWbSel=0 one cycle later; oBusy=0 next cycle.
- During WAIT on r5: ALU reading r5 -> oStall=1 until WB ends; ALU reading r3/r4 writing r6 -> oStall=0; FPU op -> oStall=1.
- FPU pending, iMduDone pulses -> ignored, stays WAIT; iFpuDone -> WB with oWbSel=1.
- iRst_n low during WAIT -> immediate IDLE, oStall=0, no oWbEn after release even if done arrives.
- EXU_TIMEOUT_EN, TIMEOUT_CYCLES=8, no done -> oTimeout=1 exactly once after 8 WAIT cycles, no oWbEn, oBusy=0 next cycle.
